// File: rtl/uart_cmd_controller_pkg.sv
// Shared state codes, opcodes and reply codes for the UART command controller.
package uart_cmd_controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_COLLECT = 4'd1,
        ST_PARSE   = 4'd2,
        ST_TX_WAIT = 4'd3,
        ST_TX_ACK  = 4'd4
    } state_t;

    localparam logic [7:0] OP_PING     = 8'hF0;
    localparam logic [7:0] OP_EN       = 8'hA0;
    localparam logic [7:0] OP_DIS      = 8'hB0;
    localparam logic [7:0] OP_STATUS   = 8'hC0;
    localparam logic [7:0] OP_ALL_ON   = 8'hFA;
    localparam logic [7:0] OP_ALL_OFF  = 8'hFB;

    localparam logic [7:0] RPL_TIMEOUT  = 8'hEC;
    localparam logic [7:0] RPL_BAD_CH   = 8'hED;
    localparam logic [7:0] RPL_MISMATCH = 8'hEE;
    localparam logic [7:0] RPL_UNKNOWN  = 8'hEF;

endpackage

// File: rtl/uart_cmd_controller_frame_collector.sv
// Gathers REPEAT identical bytes into one frame: byte count, compare and inter-byte timer.
module cmd_frame_collector
    import uart_cmd_controller_pkg::*;
#(
    parameter int unsigned REPEAT      = 2,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  state_t     i_state,
    input  logic       i_rx_ready,
    input  logic [7:0] i_rx_data,
    output logic       o_frame_valid_c,
    output logic [7:0] o_frame_byte,
    output logic       o_mismatch,
    output logic       o_timeout_c
);

    localparam int unsigned CNT_W = $clog2(REPEAT + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_count;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_first;
    logic             r_mismatch;
    logic             w_collect;
    logic             w_tmr_done;

    assign w_collect  = (i_state == ST_COLLECT);
    assign w_tmr_done = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    // Timeout wins over a byte arriving in the same cycle.
    assign o_timeout_c     = w_collect && w_tmr_done;
    assign o_frame_valid_c = w_collect && i_rx_ready && !w_tmr_done &&
                             (r_count == CNT_W'(REPEAT - 1));
    assign o_frame_byte    = r_first;
    assign o_mismatch      = r_mismatch;

    // Count, compare and time bytes; everything clears on entry to COLLECT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_timer    <= '0;
            r_first    <= 8'h00;
            r_mismatch <= 1'b0;
        end else if (i_state == ST_IDLE && i_rx_ready) begin
            r_first    <= i_rx_data;
            r_count    <= CNT_W'(1);
            r_timer    <= '0;
            r_mismatch <= 1'b0;
        end else if (w_collect && !w_tmr_done) begin
            if (i_rx_ready) begin
                if (i_rx_data != r_first) begin
                    r_mismatch <= 1'b1;
                end
                r_count <= r_count + CNT_W'(1);
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_controller.sv
// Command controller: validates repeated-byte frames, drives channel enables, replies over UART.
module uart_cmd_controller
    import uart_cmd_controller_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned REPEAT      = 2,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_rx_ready,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_idle,
    output logic              uart_tx_sig,
    output logic [7:0]        uart_tx_data,
    input  logic              SW1,
    output logic              r2t_delay,
    output logic [NUM_CH-1:0] rom_en,
    output logic [3:0]        LED,
    output logic [7:0]        tp
);

    state_t            r_state, w_state_n;
    logic [NUM_CH-1:0] r_rom_en, w_rom_en_n;
    logic              r_tx_sig, w_tx_sig_n;
    logic [7:0]        r_tx_data, w_tx_data_n;
    logic [7:0]        r_reply0, w_reply0_n;
    logic [7:0]        r_reply1, w_reply1_n;
    logic              r_two, w_two_n;
    logic              r_drop, r_tout;
    logic              w_frame_valid, w_mismatch, w_timeout, w_drop;
    logic [7:0]        w_frame_byte;

    cmd_frame_collector #(
        .REPEAT      (REPEAT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_collector (
        .clock           (clock),
        .reset           (reset),
        .i_state         (r_state),
        .i_rx_ready      (uart_rx_ready),
        .i_rx_data       (uart_rx_data),
        .o_frame_valid_c (w_frame_valid),
        .o_frame_byte    (w_frame_byte),
        .o_mismatch      (w_mismatch),
        .o_timeout_c     (w_timeout)
    );

    assign w_drop = uart_rx_ready &&
                    (r_state == ST_PARSE || r_state == ST_TX_WAIT || r_state == ST_TX_ACK);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_n;
    end

    // Next state, reply selection and channel-enable updates.
    always_comb begin
        w_state_n   = r_state;
        w_rom_en_n  = r_rom_en;
        w_tx_sig_n  = 1'b0;
        w_tx_data_n = r_tx_data;
        w_reply0_n  = r_reply0;
        w_reply1_n  = r_reply1;
        w_two_n     = r_two;
        case (r_state)
            ST_IDLE: begin
                if (uart_rx_ready) w_state_n = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_timeout) begin
                    w_reply0_n = RPL_TIMEOUT;
                    w_two_n    = 1'b0;
                    w_state_n  = ST_TX_WAIT;
                end else if (w_frame_valid) begin
                    w_state_n = ST_PARSE;
                end
            end
            ST_PARSE: begin
                w_state_n = ST_TX_WAIT;
                w_two_n   = 1'b0;
                if (w_mismatch) begin
                    w_reply0_n = RPL_MISMATCH;
                end else if (w_frame_byte == OP_PING) begin
                    w_reply0_n = OP_PING;
                end else if (w_frame_byte[7:4] == OP_EN[7:4] ||
                             w_frame_byte[7:4] == OP_DIS[7:4]) begin
                    if (32'(w_frame_byte[3:0]) < NUM_CH) begin
                        for (int i = 0; i < int'(NUM_CH); i++) begin
                            if (w_frame_byte[3:0] == 4'(i)) begin
                                w_rom_en_n[i] = (w_frame_byte[7:4] == OP_EN[7:4]);
                            end
                        end
                        w_reply0_n = w_frame_byte;
                    end else begin
                        w_reply0_n = RPL_BAD_CH;
                    end
                end else if (w_frame_byte == OP_STATUS) begin
                    // Status snapshot is frozen here for the whole two-byte reply.
                    w_reply0_n = OP_STATUS;
                    w_reply1_n = 8'(r_rom_en);
                    w_two_n    = 1'b1;
                end else if (w_frame_byte == OP_ALL_ON) begin
                    w_rom_en_n = '1;
                    w_reply0_n = OP_ALL_ON;
                end else if (w_frame_byte == OP_ALL_OFF) begin
                    w_rom_en_n = '0;
                    w_reply0_n = OP_ALL_OFF;
                end else begin
                    w_reply0_n = RPL_UNKNOWN;
                end
            end
            ST_TX_WAIT: begin
                if (uart_idle) begin
                    w_tx_sig_n  = 1'b1;
                    w_tx_data_n = r_reply0;
                    if (r_two) begin
                        w_reply0_n = r_reply1;
                        w_two_n    = 1'b0;
                        w_state_n  = ST_TX_ACK;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
            ST_TX_ACK: begin
                if (!uart_idle) w_state_n = ST_TX_WAIT;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Registered outputs and reply buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rom_en  <= '0;
            r_tx_sig  <= 1'b0;
            r_tx_data <= 8'h00;
            r_reply0  <= 8'h00;
            r_reply1  <= 8'h00;
            r_two     <= 1'b0;
            r_drop    <= 1'b0;
            r_tout    <= 1'b0;
        end else begin
            r_rom_en  <= w_rom_en_n;
            r_tx_sig  <= w_tx_sig_n;
            r_tx_data <= w_tx_data_n;
            r_reply0  <= w_reply0_n;
            r_reply1  <= w_reply1_n;
            r_two     <= w_two_n;
            r_drop    <= w_drop;
            r_tout    <= w_timeout;
        end
    end

    assign uart_tx_sig  = r_tx_sig;
    assign uart_tx_data = r_tx_data;
    assign rom_en       = r_rom_en;
    assign r2t_delay    = SW1;
    assign LED          = r_state;
    assign tp           = {r_tout, r_drop, r_tx_sig, uart_rx_ready, r_state};

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Self-checking bench: directed frames plus random frames against a behavioural reply model.
module tb_uart_cmd_controller;

    localparam int unsigned TB_NUM_CH = 4;
    localparam int unsigned TB_TOUT   = 50;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset = 1'b1;
    logic       sw1 = 1'b0;

    logic       rxr_a = 1'b0, rxr_b = 1'b0;
    logic [7:0] rxd_a = 8'h00, rxd_b = 8'h00;
    logic       emu_idle_a = 1'b1, emu_idle_b = 1'b1;
    logic       busy_a = 1'b0, busy_b = 1'b0;
    logic       idle_a, idle_b;
    assign idle_a = emu_idle_a & ~busy_a;
    assign idle_b = emu_idle_b & ~busy_b;

    logic       tx_sig_a, tx_sig_b, r2t_a, r2t_b;
    logic [7:0] tx_data_a, tx_data_b, tp_a, tp_b;
    logic [3:0] rom_en_a, rom_en_b, led_a, led_b;

    uart_cmd_controller #(.NUM_CH(TB_NUM_CH), .REPEAT(2), .TIMEOUT_CYC(TB_TOUT)) dut_a (
        .clock(clock), .reset(reset), .uart_rx_ready(rxr_a), .uart_rx_data(rxd_a),
        .uart_idle(idle_a), .uart_tx_sig(tx_sig_a), .uart_tx_data(tx_data_a),
        .SW1(sw1), .r2t_delay(r2t_a), .rom_en(rom_en_a), .LED(led_a), .tp(tp_a));

    uart_cmd_controller #(.NUM_CH(TB_NUM_CH), .REPEAT(3), .TIMEOUT_CYC(TB_TOUT)) dut_b (
        .clock(clock), .reset(reset), .uart_rx_ready(rxr_b), .uart_rx_data(rxd_b),
        .uart_idle(idle_b), .uart_tx_sig(tx_sig_b), .uart_tx_data(tx_data_b),
        .SW1(sw1), .r2t_delay(r2t_b), .rom_en(rom_en_b), .LED(led_b), .tp(tp_b));

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] txq_a[$], txq_b[$];
    int         txc_a[$], txc_b[$];
    int         drop_a = 0, drop_b = 0, tout_a = 0;

    // Record transmitted bytes and test-point pulses.
    always @(negedge clock) begin
        if (tx_sig_a) begin txq_a.push_back(tx_data_a); txc_a.push_back(cyc); end
        if (tx_sig_b) begin txq_b.push_back(tx_data_b); txc_b.push_back(cyc); end
        if (tp_a[6]) drop_a++;
        if (tp_b[6]) drop_b++;
        if (tp_a[7]) tout_a++;
    end

    // Transmitter emulation: busy for 5 cycles after each accepted byte.
    always begin
        @(negedge clock);
        if (tx_sig_a) begin
            emu_idle_a = 1'b0;
            repeat (5) @(negedge clock);
            emu_idle_a = 1'b1;
        end
    end
    always begin
        @(negedge clock);
        if (tx_sig_b) begin
            emu_idle_b = 1'b0;
            repeat (5) @(negedge clock);
            emu_idle_b = 1'b1;
        end
    end

    int errors = 0;
    int checks = 0;
    int last_edge = 0;
    logic [7:0] model_en_a = 8'h00, model_en_b = 8'h00;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=hang required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reply rules derived directly from the command table.
    function automatic void model(input logic [7:0] b0, input bit mis, input logic [7:0] en_in,
                                  output logic [7:0] en_out, output logic [7:0] r0,
                                  output logic [7:0] r1, output int nrep);
        int c;
        en_out = en_in;
        r1     = 8'h00;
        nrep   = 1;
        c      = int'(b0) % 16;
        if (mis)                           r0 = 8'hEE;
        else if (b0 == 8'hF0)              r0 = 8'hF0;
        else if (b0 >= 8'hA0 && b0 <= 8'hAF) begin
            if (c < int'(TB_NUM_CH)) begin en_out = en_in | 8'(1 << c); r0 = b0; end
            else r0 = 8'hED;
        end else if (b0 >= 8'hB0 && b0 <= 8'hBF) begin
            if (c < int'(TB_NUM_CH)) begin en_out = en_in & ~8'(1 << c); r0 = b0; end
            else r0 = 8'hED;
        end else if (b0 == 8'hC0) begin
            r0 = 8'hC0; r1 = en_in; nrep = 2;
        end else if (b0 == 8'hFA) begin
            en_out = 8'((1 << TB_NUM_CH) - 1); r0 = 8'hFA;
        end else if (b0 == 8'hFB) begin
            en_out = 8'h00; r0 = 8'hFB;
        end else                           r0 = 8'hEF;
    endfunction

    task automatic send_byte(input int d, input logic [7:0] v);
        @(negedge clock);
        if (d == 0) begin rxr_a = 1'b1; rxd_a = v; end
        else        begin rxr_b = 1'b1; rxd_b = v; end
        last_edge = cyc + 1;
        @(negedge clock);
        rxr_a = 1'b0;
        rxr_b = 1'b0;
    endtask

    task automatic wait_ready(input int d);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (d == 0 ? (led_a == 4'd0 && idle_a) : (led_b == 4'd0 && idle_b)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_wait", 32'(ok), 1);
    endtask

    task automatic wait_tx(input int d, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if ((d == 0 ? txq_a.size() : txq_b.size()) >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_frame(input int d, input string tag, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input bit chk_lat);
        logic [7:0] en_out, r0, r1, g0, g1;
        int nrep, got_n, c0, c1;
        bit mis, ok;
        mis = (b1 != b0) || (d != 0 && b2 != b0);
        model(b0, mis, (d == 0) ? model_en_a : model_en_b, en_out, r0, r1, nrep);
        wait_ready(d);
        txq_a.delete(); txc_a.delete(); txq_b.delete(); txc_b.delete();
        send_byte(d, b0);
        send_byte(d, b1);
        if (d != 0) send_byte(d, b2);
        wait_tx(d, nrep, 100, ok);
        chk({tag, "_reply_seen"}, 32'(ok), 1);
        repeat (10) @(negedge clock);
        got_n = (d == 0) ? txq_a.size() : txq_b.size();
        g0 = 8'h00; g1 = 8'h00; c0 = 0; c1 = 0;
        if (got_n >= 1) begin
            g0 = (d == 0) ? txq_a[0] : txq_b[0];
            c0 = (d == 0) ? txc_a[0] : txc_b[0];
        end
        if (got_n >= 2) begin
            g1 = (d == 0) ? txq_a[1] : txq_b[1];
            c1 = (d == 0) ? txc_a[1] : txc_b[1];
        end
        chk({tag, "_reply_count"}, got_n, nrep);
        chk({tag, "_byte0"}, 32'(g0), 32'(r0));
        if (nrep == 2) begin
            chk({tag, "_byte1"}, 32'(g1), 32'(r1));
            chk({tag, "_second_waits_idle"}, 32'((c1 - c0) >= 6), 1);
        end
        if (chk_lat) chk({tag, "_latency"}, c0 - last_edge, 2);
        if (d == 0) model_en_a = en_out; else model_en_b = en_out;
        chk({tag, "_rom_en"}, 32'((d == 0) ? rom_en_a : rom_en_b),
            32'((d == 0) ? model_en_a : model_en_b));
    endtask

    initial begin
        int kind, ch, t0, d0, lat;
        logic [7:0] b0, b1;
        bit ok;

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_tx_sig", 32'(tx_sig_a), 0);
        chk("rst_tx_data", 32'(tx_data_a), 0);
        chk("rst_rom_en", 32'(rom_en_a), 0);
        chk("rst_led", 32'(led_a), 0);
        chk("rst_tp_pulses", 32'(tp_a[7:5]), 0);
        @(negedge clock);
        reset = 1'b0;
        chk("r2t_low", 32'(r2t_a), 0);
        sw1 = 1'b1;
        #1;
        chk("r2t_high", 32'(r2t_a), 1);
        sw1 = 1'b0;

        // Directed frames.
        run_frame(0, "en2",      8'hA2, 8'hA2, 8'h00, 1'b1);
        run_frame(0, "en1",      8'hA1, 8'hA1, 8'h00, 1'b1);
        run_frame(0, "status",   8'hC0, 8'hC0, 8'h00, 1'b1);
        run_frame(0, "mismatch", 8'hA1, 8'hA3, 8'h00, 1'b1);
        run_frame(0, "bad_ch",   8'hA5, 8'hA5, 8'h00, 1'b1);
        run_frame(0, "unknown",  8'h33, 8'h33, 8'h00, 1'b1);

        // Inter-byte timeout.
        wait_ready(0);
        txq_a.delete(); txc_a.delete();
        t0 = tout_a;
        send_byte(0, 8'hF0);
        wait_tx(0, 1, 150, ok);
        chk("tout_reply_seen", 32'(ok), 1);
        repeat (5) @(negedge clock);
        chk("tout_reply_count", txq_a.size(), 1);
        if (txq_a.size() >= 1) begin
            chk("tout_byte", 32'(txq_a[0]), 32'hEC);
            lat = txc_a[0] - last_edge;
            chk("tout_latency", 32'(lat >= int'(TB_TOUT) - 1 && lat <= int'(TB_TOUT) + 1), 1);
        end
        chk("tout_pulse_once", tout_a - t0, 1);
        chk("tout_led_idle", 32'(led_a), 0);

        // Random frames.
        for (int k = 0; k < 24; k++) begin
            kind = int'($urandom_range(0, 7));
            ch   = int'($urandom_range(0, 7));
            case (kind)
                0:       b0 = 8'hF0;
                1:       b0 = 8'hA0 + 8'(ch);
                2:       b0 = 8'hB0 + 8'(ch);
                3:       b0 = 8'hC0;
                4:       b0 = 8'hFA;
                5:       b0 = 8'hFB;
                default: b0 = 8'($urandom_range(0, 255));
            endcase
            b1 = (kind == 7) ? (b0 ^ 8'($urandom_range(1, 255))) : b0;
            run_frame(0, "rand", b0, b1, 8'h00, 1'b1);
        end

        // Three-byte frames and dropped bytes during reply.
        run_frame(1, "rep3_ping", 8'hF0, 8'hF0, 8'hF0, 1'b1);
        run_frame(1, "rep3_mis",  8'hF0, 8'hF0, 8'hF1, 1'b1);
        wait_ready(1);
        busy_b = 1'b1;
        txq_b.delete(); txc_b.delete();
        d0 = drop_b;
        send_byte(1, 8'hA0);
        send_byte(1, 8'hA0);
        send_byte(1, 8'hA0);
        repeat (3) @(negedge clock);
        chk("drop_in_tx_wait_state", 32'(led_b), 3);
        send_byte(1, 8'h55);
        repeat (3) @(negedge clock);
        chk("drop_pulse", drop_b - d0, 1);
        busy_b = 1'b0;
        wait_tx(1, 1, 100, ok);
        chk("drop_reply_seen", 32'(ok), 1);
        repeat (12) @(negedge clock);
        chk("drop_reply_count", txq_b.size(), 1);
        if (txq_b.size() >= 1) chk("drop_reply_byte", 32'(txq_b[0]), 32'h A0);
        chk("drop_rom_en", 32'(rom_en_b), 1);

        // Reset while waiting to transmit.
        wait_ready(0);
        busy_a = 1'b1;
        send_byte(0, 8'hFA);
        send_byte(0, 8'hFA);
        repeat (3) @(negedge clock);
        chk("rstmid_state", 32'(led_a), 3);
        chk("rstmid_rom_en_set", 32'(rom_en_a), 32'h F);
        txq_a.delete(); txc_a.delete();
        reset = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        busy_a = 1'b0;
        repeat (6) @(negedge clock);
        chk("rstmid_no_strobe", txq_a.size(), 0);
        chk("rstmid_rom_en", 32'(rom_en_a), 0);
        chk("rstmid_led", 32'(led_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
